// File: rtl/ps2_kbd_matrix.sv
// ps2_kbd_matrix: PS/2 set-2 receiver and decoder that keeps a 7x8 CoCo key matrix and answers PIA0 column strobes with row levels; optional PS2_OVERRUN_CLEAR_EN makes AA/FF/00 release every key
module ps2_kbd_matrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  input  logic [7:0] i_kb_cols,
  output logic [7:0] o_kb_rows,
  output logic [7:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Scan code {ext,byte} per matrix slot r*8+c; slot 56 is the second shift key. 0F0 marks unused slots (F0 is never looked up).
  localparam logic [8:0] KMAP [57] = '{
    9'h054, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034,
    9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044,
    9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D,
    9'h022, 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029,
    9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
    9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A,
    9'h05A, 9'h16C, 9'h076, 9'h0F0, 9'h0F0, 9'h0F0, 9'h0F0, 9'h012,
    9'h059
  };
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
  state_t         r_state, w_next;
  logic [1:0]     r_clk_s, r_dat_s;
  logic           r_filt, r_filt_d;
  logic [FW-1:0]  r_fcnt;
  logic [2:0]     r_bits;
  logic [7:0]     r_shift;
  logic           r_par_ok;
  logic [TW-1:0]  r_to;
  logic           r_ext, r_brk;
  logic [56:0]    r_key;
  logic [7:0]     r_rows, r_code;
  logic           r_valid, r_err;
  logic           w_fall, w_dat, w_tout, w_good, w_bad, w_hit, w_ovr;
  logic [5:0]     w_idx;
  logic [55:0]    w_mat;
  logic [7:0]     w_rows;
  assign w_fall = r_filt_d & ~r_filt;
  assign w_dat  = r_dat_s[1];
  assign w_tout = (r_state != S_IDLE) && (r_to == TW'(TIMEOUT));
  assign w_mat  = {r_key[56] | r_key[55], r_key[54:0]};
`ifdef PS2_OVERRUN_CLEAR_EN
  assign w_ovr = (r_shift == 8'hAA) || (r_shift == 8'hFF) || (r_shift == 8'h00);
`else
  assign w_ovr = 1'b0;
`endif
  assign o_kb_rows   = r_rows;
  assign o_key_code  = r_code;
  assign o_key_valid = r_valid;
  assign o_frame_err = r_err;
  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
    end else begin
      r_clk_s <= {r_clk_s[0], i_ps2_clk};
      r_dat_s <= {r_dat_s[0], i_ps2_dat};
    end
  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_s[1] == r_filt) r_fcnt <= '0;
      else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s[1];
        r_fcnt <= '0;
      end else r_fcnt <= r_fcnt + 1'b1;
    end
  // Frame state register
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  // Frame next state; a good or bad frame is decided on the stop edge, timeout wins over an edge
  always_comb begin
    w_next = r_state;
    w_good = 1'b0;
    w_bad  = 1'b0;
    if (w_tout) begin
      w_next = S_IDLE;
      w_bad  = 1'b1;
    end else if (w_fall)
      case (r_state)
        S_IDLE:   w_next = w_dat ? S_IDLE : S_DATA;
        S_DATA:   w_next = (r_bits == 3'd7) ? S_PARITY : S_DATA;
        S_PARITY: w_next = S_STOP;
        default: begin
          w_next = S_IDLE;
          w_good = w_dat & r_par_ok;
          w_bad  = ~(w_dat & r_par_ok);
        end
      endcase
  end
  // Shift register, bit counter, parity and inter-edge timeout
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_bits   <= '0;
      r_shift  <= '0;
      r_par_ok <= 1'b0;
      r_to     <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_code   <= '0;
    end else begin
      r_to    <= (w_fall || r_state == S_IDLE) ? '0 : r_to + 1'b1;
      r_valid <= w_good;
      r_err   <= w_bad;
      if (w_good) r_code <= r_shift;
      if (w_fall && r_state == S_IDLE) r_bits <= '0;
      if (w_fall && r_state == S_DATA) begin
        r_shift <= {w_dat, r_shift[7:1]};
        r_bits  <= r_bits + 1'b1;
      end
      if (w_fall && r_state == S_PARITY) r_par_ok <= ^{w_dat, r_shift};
    end
  // Scan-code lookup of the received byte with the pending extended flag
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < 57; i++)
      if (KMAP[i] == {r_ext, r_shift}) begin
        w_hit = 1'b1;
        w_idx = 6'(i);
      end
  end
  // Decoder: prefix bytes accumulate flags, any other byte updates the matrix and clears them
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
      r_key <= '0;
    end else if (w_good) begin
      if (r_shift == 8'hE0) r_ext <= 1'b1;
      else if (r_shift == 8'hF0) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (w_ovr) r_key <= '0;
        else if (w_hit) r_key[w_idx] <= ~r_brk;
      end
    end
  // Row sense: a row goes low when any strobed column holds a pressed key
  always_comb begin
    w_rows = 8'h80;
    for (int r = 0; r < 7; r++) w_rows[r] = ~|(w_mat[r*8 +: 8] & ~i_kb_cols);
  end
  // Registered row outputs
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_rows <= 8'hFF;
    else r_rows <= w_rows;
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// tb_ps2_kbd_matrix: directed PS/2 frames against a byte-level keyboard model
module tb_ps2_kbd_matrix;
  localparam int H = 16;
  localparam int TIMEOUT = 50000;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_dat = 1;
  logic [7:0] kb_cols = 8'hFF;
  logic [7:0] kb_rows, key_code;
  logic key_valid, frame_err;
  int n_chk = 0, n_fail = 0, nv = 0, ne = 0;
  bit settled = 0;
  logic [8:0] ktab [57] = '{
    9'h054, 9'h01C, 9'h032, 9'h021, 9'h023, 9'h024, 9'h02B, 9'h034,
    9'h033, 9'h043, 9'h03B, 9'h042, 9'h04B, 9'h03A, 9'h031, 9'h044,
    9'h04D, 9'h015, 9'h02D, 9'h01B, 9'h02C, 9'h03C, 9'h02A, 9'h01D,
    9'h022, 9'h035, 9'h01A, 9'h175, 9'h172, 9'h16B, 9'h174, 9'h029,
    9'h045, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E, 9'h036, 9'h03D,
    9'h03E, 9'h046, 9'h052, 9'h04C, 9'h041, 9'h04E, 9'h049, 9'h04A,
    9'h05A, 9'h16C, 9'h076, 9'h0F0, 9'h0F0, 9'h0F0, 9'h0F0, 9'h012,
    9'h059
  };
  int pos_of [int];
  bit pressed [int];
  bit m_ext = 0, m_brk = 0;
  logic [7:0] m_code = 8'h00;
  always #5 clk = ~clk;
  ps2_kbd_matrix dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_dat(ps2_dat),
    .i_kb_cols(kb_cols), .o_kb_rows(kb_rows), .o_key_code(key_code),
    .o_key_valid(key_valid), .o_frame_err(frame_err)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] exp_rows(logic [7:0] cols);
    logic [7:0] r = 8'hFF;
    foreach (pressed[k]) if (pressed[k] && !cols[pos_of[k] % 8]) r[pos_of[k] / 8] = 1'b0;
    return r;
  endfunction
  task automatic model_byte(logic [7:0] b);
    int k = int'({m_ext, b});
    m_code = b;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
`ifdef PS2_OVERRUN_CLEAR_EN
      if (b == 8'hAA || b == 8'hFF || b == 8'h00) pressed.delete();
      else
`endif
      if (pos_of.exists(k)) pressed[k] = !m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_bits(logic [10:0] bits, int nb);
    for (int i = 0; i < nb; i++) begin
      ps2_dat = bits[i];
      tick(H);
      ps2_clk = 0;
      tick(H);
      ps2_clk = 1;
    end
  endtask
  task automatic send(logic [7:0] b, bit bad_par = 0, bit bad_stop = 0);
    int v0 = nv, e0 = ne, good = (!bad_par && !bad_stop) ? 1 : 0;
    settled = 0;
    send_bits({~bad_stop, (~^b) ^ bad_par, b, 1'b0}, 11);
    ps2_dat = 1;
    tick(30);
    if (good == 1) model_byte(b);
    chk($sformatf("valid_pulses_%h", b), nv - v0, good);
    chk($sformatf("err_pulses_%h", b), ne - e0, 1 - good);
    settled = 1;
  endtask
  task automatic set_cols(logic [7:0] c);
    settled = 0;
    kb_cols = c;
    tick(2);
    settled = 1;
  endtask
  initial begin
    int v0, e0;
    for (int i = 0; i < 57; i++) if (ktab[i] != 9'h0F0) pos_of[int'(ktab[i])] = (i == 56) ? 55 : i;
    fork
      forever begin
        @(negedge clk);
        if (key_valid) nv++;
        if (frame_err) ne++;
        if (settled) begin
          chk("rows_vs_model", kb_rows, exp_rows(kb_cols));
          chk("code_vs_model", key_code, m_code);
        end
      end
    join_none
    tick(3);
    chk("reset_rows", kb_rows, 8'hFF);
    chk("reset_code", key_code, 8'h00);
    chk("reset_valid", key_valid, 0);
    chk("reset_err", frame_err, 0);
    rst_n = 1;
    tick(2);
    settled = 1;
    send(8'h1C);
    chk("t1_code", key_code, 8'h1C);
    set_cols(8'hFD);
    chk("t1_rows_fd", kb_rows, 8'hFE);
    set_cols(8'hFF);
    chk("t1_rows_ff", kb_rows, 8'hFF);
    send(8'hF0); send(8'h1C);
    set_cols(8'h00);
    chk("t2_break", kb_rows, 8'hFF);
    send(8'h1C); send(8'h32);
    chk("t2_ab", kb_rows, 8'hFE);
    set_cols(8'hF7);
    send(8'hE0); send(8'h75);
    chk("t3_up", kb_rows, 8'hF7);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t3_up_break", kb_rows, 8'hFF);
    send(8'hE0); send(8'h12);
    chk("t3_fake_shift", kb_rows, 8'hFF);
    chk("t3_code", key_code, 8'h12);
    set_cols(8'h7F);
    send(8'h12); send(8'h59);
    chk("shift_both", kb_rows, 8'hBF);
    send(8'hF0); send(8'h12);
    chk("shift_one_left", kb_rows, 8'hBF);
    send(8'hF0); send(8'h59);
    chk("shift_none", kb_rows, 8'hFF);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h32);
    set_cols(8'h00);
    chk("t4_clear", kb_rows, 8'hFF);
    send(8'h1C, 1);
    chk("t4_code_held", key_code, 8'h32);
    chk("t4_rows", kb_rows, 8'hFF);
    send(8'h5A, 0, 1);
    chk("bad_stop_code", key_code, 8'h32);
    v0 = nv; e0 = ne;
    send_bits({1'b1, ~^8'h1C, 8'h1C, 1'b0}, 5);
    ps2_dat = 1;
    tick(TIMEOUT + 100);
    chk("t5_timeout_err", ne - e0, 1);
    chk("t5_timeout_valid", nv - v0, 0);
    send(8'h1C);
    chk("t5_after_rows", kb_rows, 8'hFE);
    chk("t5_after_code", key_code, 8'h1C);
    send_bits({1'b1, ~^8'h16, 8'h16, 1'b0}, 4);
    ps2_dat = 1;
    settled = 0;
    rst_n = 0;
    #1;
    pressed.delete();
    m_ext = 0; m_brk = 0; m_code = 8'h00;
    chk("t5_reset_rows", kb_rows, 8'hFF);
    chk("t5_reset_code", key_code, 8'h00);
    tick(2);
    rst_n = 1;
    tick(2);
    settled = 1;
    set_cols(8'h00);
    chk("t5_matrix_clear", kb_rows, 8'hFF);
    send(8'h1C);
    set_cols(8'hFD);
    chk("t6_a", kb_rows, 8'hFE);
    send(8'hAA);
    chk("t6_code", key_code, 8'hAA);
`ifdef PS2_OVERRUN_CLEAR_EN
    chk("t6_overrun", kb_rows, 8'hFF);
`else
    chk("t6_overrun", kb_rows, 8'hFE);
`endif
    settled = 0;
    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
